// File: rtl/mac_vert_pkg.sv
// mac_vert_pkg: shared definitions for the vertical bit-serial MAC.
// Holds the sequencer state type, the width helpers that derive the
// datapath widths, and the slot-to-activation index mapping.
package mac_vert_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SUM,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Width of one group's activation sum.
  function automatic int gsum_width(input int data_width, input int group_size);
    return data_width + $clog2(group_size);
  endfunction

  // Width of the column total across all groups, with headroom for the
  // group_sum - psum form, which can exceed a plain group sum by one bit.
  function automatic int tot_width(input int gsum_w, input int ngroup);
    return gsum_w + $clog2(ngroup) + 1;
  endfunction

  // Slot k of group g looks at a window offset by sel inside its group.
  function automatic int slot_index(input int g, input int k, input int sel,
                                    input int group_size);
    return g * group_size + k + sel;
  endfunction

endpackage

// File: rtl/mac_vert_col_term.sv
// mac_vert_col_term: combinational column term for one weight bit column.
// Selects each slot's activation, sums slots per group (psum), picks
// psum or group_sum - psum per group, totals the groups, optionally negates
// (sign column) and shifts by the column's bit position.
// Ports:
//   act_vec       - latched activations, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   group_sum     - registered per-group activation sums, GSUM_W each
//   col_sel       - per-slot window offset, SEL_W each
//   col_val       - per-slot valid
//   col_skip_zero - per-group: 1 uses psum, 0 uses group_sum - psum
//   col_idx       - left shift applied to the column total
//   col_msb       - negate the column total
//   col_term      - signed, sign-extended shifted column total
module mac_vert_col_term
  import mac_vert_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16,
  parameter int GROUP_SIZE = 8,
  parameter int W_BITS     = 8,
  parameter int ACC_WIDTH  = DATA_WIDTH + 16,
  localparam int NGROUP = VEC_LENGTH / GROUP_SIZE,
  localparam int NSLOT  = VEC_LENGTH / 2,
  localparam int HALF   = GROUP_SIZE / 2,
  localparam int SEL_W  = $clog2(GROUP_SIZE / 2 + 1),
  localparam int IDX_W  = $clog2(W_BITS),
  localparam int GSUM_W = gsum_width(DATA_WIDTH, GROUP_SIZE),
  localparam int TOT_W  = tot_width(GSUM_W, NGROUP)
) (
  input  logic [VEC_LENGTH*DATA_WIDTH-1:0] act_vec,
  input  logic [NGROUP*GSUM_W-1:0]         group_sum,
  input  logic [NSLOT*SEL_W-1:0]           col_sel,
  input  logic [NSLOT-1:0]                 col_val,
  input  logic [NGROUP-1:0]                col_skip_zero,
  input  logic [IDX_W-1:0]                 col_idx,
  input  logic                             col_msb,
  output logic signed [ACC_WIDTH-1:0]      col_term
);

  logic signed [DATA_WIDTH-1:0] slot_val [NSLOT];
  logic signed [GSUM_W:0]       term     [NGROUP];
  logic signed [TOT_W-1:0]      tot;
  logic signed [TOT_W-1:0]      tot_signed;

  genvar gi, ki;
  generate
    for (gi = 0; gi < NGROUP; gi++) begin : g_group
      for (ki = 0; ki < HALF; ki++) begin : g_slot
        localparam int SLOT = gi * HALF + ki;
        logic [SEL_W-1:0] sel;
        logic             in_window;
        int               act_idx;

        assign sel       = col_sel[SLOT*SEL_W +: SEL_W];
        // Offsets past the half-group would leave the group, so they count as 0.
        assign in_window = col_val[SLOT] && (int'(sel) <= HALF);
        // Keep the index inside the vector even when the slot is masked off.
        assign act_idx   = in_window ? slot_index(gi, ki, int'(sel), GROUP_SIZE)
                                     : slot_index(gi, ki, 0, GROUP_SIZE);
        assign slot_val[SLOT] = in_window
                              ? $signed(act_vec[act_idx*DATA_WIDTH +: DATA_WIDTH])
                              : '0;
      end

      logic signed [GSUM_W-1:0] psum;
      logic signed [GSUM_W-1:0] gsum;

      always_comb begin
        psum = '0;
        for (int k = 0; k < HALF; k++) begin
          psum = psum + GSUM_W'(slot_val[gi*HALF + k]);
        end
      end

      assign gsum     = $signed(group_sum[gi*GSUM_W +: GSUM_W]);
      assign term[gi] = col_skip_zero[gi]
                      ? (GSUM_W+1)'(psum)
                      : (GSUM_W+1)'(gsum) - (GSUM_W+1)'(psum);
    end
  endgenerate

  always_comb begin
    tot = '0;
    for (int g = 0; g < NGROUP; g++) begin
      tot = tot + TOT_W'(term[g]);
    end
  end

  assign tot_signed = col_msb ? -tot : tot;
  assign col_term   = ACC_WIDTH'(tot_signed) << col_idx;

endmodule

// File: rtl/mac_unit_vert_seq.sv
// mac_unit_vert_seq: self-sequencing bit-serial vertical MAC.
// Latches one signed activation vector, precomputes per-group sums, then
// accumulates one weight bit column per accepted descriptor through a
// two-stage pipeline (column term register, then accumulator) and finally
// presents the accumulator on a valid/ready output.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   act_valid/act_ready, act   - activation vector load handshake
//   load_accum, accum_prev     - optional accumulator seed, sampled with act
//   col_valid/col_ready, col_* - weight bit column descriptor stream
//   out_valid/out_ready        - result handshake
//   result                     - top RESULT_WIDTH bits of the accumulator
//   acc_out                    - full accumulator
//   err_overflow               - sticky: column limit reached without col_last
module mac_unit_vert_seq
  import mac_vert_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int VEC_LENGTH   = 16,
  parameter int GROUP_SIZE   = 8,
  parameter int W_BITS       = 8,
  parameter int ACC_WIDTH    = DATA_WIDTH + 16,
  parameter int RESULT_WIDTH = 2 * DATA_WIDTH,
  localparam int NGROUP = VEC_LENGTH / GROUP_SIZE,
  localparam int NSLOT  = VEC_LENGTH / 2,
  localparam int SEL_W  = $clog2(GROUP_SIZE / 2 + 1),
  localparam int IDX_W  = $clog2(W_BITS),
  localparam int GSUM_W = gsum_width(DATA_WIDTH, GROUP_SIZE),
  localparam int TOT_W  = tot_width(GSUM_W, NGROUP),
  localparam int CNT_W  = $clog2(W_BITS + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           act_valid,
  output logic                           act_ready,
  input  logic [VEC_LENGTH*DATA_WIDTH-1:0] act,
  input  logic                           load_accum,
  input  logic [ACC_WIDTH-1:0]           accum_prev,
  input  logic                           col_valid,
  output logic                           col_ready,
  input  logic [NSLOT*SEL_W-1:0]         col_sel,
  input  logic [NSLOT-1:0]               col_val,
  input  logic [NGROUP-1:0]              col_skip_zero,
  input  logic [IDX_W-1:0]               col_idx,
  input  logic                           col_msb,
  input  logic                           col_mul_en,
  input  logic                           col_mul_const,
  input  logic [1:0]                     col_mul_shift,
  input  logic                           col_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [RESULT_WIDTH-1:0]        result,
  output logic [ACC_WIDTH-1:0]           acc_out,
  output logic                           err_overflow
);

  state_t                            state_reg;
  logic [VEC_LENGTH*DATA_WIDTH-1:0]  act_reg;
  logic [NGROUP*GSUM_W-1:0]          group_sum_reg;
  logic [NGROUP*GSUM_W-1:0]          group_sum_next;
  logic signed [ACC_WIDTH-1:0]       acc_reg;
  logic signed [ACC_WIDTH-1:0]       stage1_reg;
  logic [CNT_W-1:0]                  cnt_reg;
  logic                              act_ready_reg;
  logic                              col_ready_reg;
  logic                              out_valid_reg;
  logic                              err_reg;

  logic                              act_fire;
  logic                              col_fire;
  logic                              col_done;
  logic signed [TOT_W-1:0]           gsum_total;
  logic signed [ACC_WIDTH-1:0]       col_term;
  logic signed [ACC_WIDTH-1:0]       mul_term;

  assign act_fire = act_valid & act_ready_reg;
  assign col_fire = col_valid & col_ready_reg;
  // The W_BITS-th column closes the dot product even without col_last.
  assign col_done = col_last || (cnt_reg == CNT_W'(W_BITS - 1));

  // Per-group activation sums from the latched vector, captured in SUM.
  genvar gi;
  generate
    for (gi = 0; gi < NGROUP; gi++) begin : g_gsum
      logic signed [GSUM_W-1:0] gs;
      always_comb begin
        gs = '0;
        for (int j = 0; j < GROUP_SIZE; j++) begin
          gs = gs + GSUM_W'($signed(act_reg[(gi*GROUP_SIZE + j)*DATA_WIDTH +: DATA_WIDTH]));
        end
      end
      assign group_sum_next[gi*GSUM_W +: GSUM_W] = gs;
    end
  endgenerate

  always_comb begin
    gsum_total = '0;
    for (int g = 0; g < NGROUP; g++) begin
      gsum_total = gsum_total + TOT_W'($signed(group_sum_reg[g*GSUM_W +: GSUM_W]));
    end
  end

  // Constant-multiplier term: a 1-bit constant, so the product is a gate.
  assign mul_term = (col_mul_en && col_mul_const)
                  ? (ACC_WIDTH'(gsum_total) << col_mul_shift)
                  : '0;

  mac_vert_col_term #(
    .DATA_WIDTH (DATA_WIDTH),
    .VEC_LENGTH (VEC_LENGTH),
    .GROUP_SIZE (GROUP_SIZE),
    .W_BITS     (W_BITS),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_col_term (
    .act_vec       (act_reg),
    .group_sum     (group_sum_reg),
    .col_sel       (col_sel),
    .col_val       (col_val),
    .col_skip_zero (col_skip_zero),
    .col_idx       (col_idx),
    .col_msb       (col_msb),
    .col_term      (col_term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      act_reg       <= '0;
      group_sum_reg <= '0;
      acc_reg       <= '0;
      stage1_reg    <= '0;
      cnt_reg       <= '0;
      act_ready_reg <= 1'b1;
      col_ready_reg <= 1'b0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      // Stage 1 holds zero on bubble cycles so stage 2 adds nothing.
      stage1_reg <= col_fire ? (col_term + mul_term) : '0;

      unique case (state_reg)
        ST_IDLE: begin
          if (act_fire) begin
            act_reg       <= act;
            acc_reg       <= load_accum ? $signed(accum_prev) : '0;
            cnt_reg       <= '0;
            act_ready_reg <= 1'b0;
            state_reg     <= ST_SUM;
          end
        end
        ST_SUM: begin
          group_sum_reg <= group_sum_next;
          col_ready_reg <= 1'b1;
          state_reg     <= ST_RUN;
        end
        ST_RUN: begin
          acc_reg <= acc_reg + stage1_reg;
          if (col_fire) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (col_done) begin
              col_ready_reg <= 1'b0;
              state_reg     <= ST_DRAIN;
              if (!col_last) begin
                err_reg <= 1'b1;
              end
            end
          end
        end
        ST_DRAIN: begin
          // Last accepted column is still in stage 1; fold it in.
          acc_reg       <= acc_reg + stage1_reg;
          out_valid_reg <= 1'b1;
          state_reg     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            act_ready_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign act_ready    = act_ready_reg;
  assign col_ready    = col_ready_reg;
  assign out_valid    = out_valid_reg;
  assign acc_out      = acc_reg;
  assign result       = acc_reg[ACC_WIDTH-1 -: RESULT_WIDTH];
  assign err_overflow = err_reg;

endmodule

// File: doc/mac_unit_vert_seq.md
Name: mac_unit_vert_seq

Overview:
- Parametrised, self-sequencing successor of the 16-lane bit-serial vertical MAC.
- Latches one signed activation vector per dot product and computes the per-group activation sums internally.
- Consumes a stream of weight bit-column descriptors under a valid/ready handshake and accumulates the shifted, sparsity-aware partial sums plus the small constant-multiplier term.
- Presents the finished accumulator on a valid/ready output; sits between the activation buffer/column scheduler and the output writeback.

Parameters:
- DATA_WIDTH, 8: activation width (signed).
- VEC_LENGTH, 16: activations per vector.
- GROUP_SIZE, 8: activations per group; must divide VEC_LENGTH, must be even.
- W_BITS, 8: maximum number of weight bit columns per dot product.
- ACC_WIDTH, DATA_WIDTH+16: accumulator width.
- RESULT_WIDTH, 2*DATA_WIDTH: truncated result width.
- Derived: NGROUP=VEC_LENGTH/GROUP_SIZE; NSLOT=VEC_LENGTH/2; SEL_W=$clog2(GROUP_SIZE/2+1); IDX_W=$clog2(W_BITS); GSUM_W=DATA_WIDTH+$clog2(GROUP_SIZE).

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high.
- act_valid / act_ready, in / out, 1 each: activation load handshake.
- act, in, NGROUP... no: act is in, VEC_LENGTH x DATA_WIDTH, signed activations.
- load_accum, in, 1: seed the accumulator from accum_prev (sampled with act).
- accum_prev, in, ACC_WIDTH: seed value.
- col_valid / col_ready, in / out, 1 each: column descriptor handshake.
- col_sel, in, NSLOT x SEL_W: per-slot window offset.
- col_val, in, NSLOT x 1: slot valid.
- col_skip_zero, in, NGROUP x 1: 1 selects psum, 0 selects group_sum - psum.
- col_idx, in, IDX_W: bit position of the column.
- col_msb, in, 1: negate the column term.
- col_mul_en, in, 1: enable the multiplier term.
- col_mul_const, in, 1: multiplier constant.
- col_mul_shift, in, 2: multiplier shift amount.
- col_last, in, 1: final column of the dot product.
- out_valid / out_ready, out / in, 1 each: result handshake.
- result, out, RESULT_WIDTH: acc[ACC_WIDTH-1 -: RESULT_WIDTH].
- acc_out, out, ACC_WIDTH: full accumulator value.
- err_overflow, out, 1: sticky; set when the column count limit is hit.

Behaviour:
- Reset: FSM goes to IDLE; accumulator, pipeline registers, latched activations, group sums, counter and err_overflow clear to 0; out_valid=0, col_ready=0, act_ready=1.
- Reset mid-operation aborts the current dot product with no output produced.
- FSM states and outputs:
  - IDLE: act_ready=1. On act_valid, latch act; acc <= load_accum ? accum_prev : 0; counter=0; go to SUM.
  - SUM: 1 cycle; registers group_sum[g] = sum of the group's GROUP_SIZE activations, width GSUM_W, signed. Go to RUN.
  - RUN: col_ready=1. Each accepted column increments the counter. Go to DRAIN when col_last is accepted, or when the counter reaches W_BITS. In the limit case the column is treated as last and err_overflow is set.
  - DRAIN: 1 cycle; flushes the stage-1 register into acc. Go to DONE.
  - DONE: out_valid=1; result and acc_out stable. On out_ready, go to IDLE; act_ready asserts the next cycle.
- Slot mapping: slot k of group g (k < GROUP_SIZE/2) selects act[g*GROUP_SIZE + k + col_sel]. Its contribution is 0 if col_val=0 or col_sel > GROUP_SIZE/2.
- Column datapath:
  - psum[g] = sum of the group's slots.
  - term[g] = col_skip_zero ? psum : group_sum - psum.
  - tot = sum over g of term[g], signed, width GSUM_W+$clog2(NGROUP)+1.
  - Apply two's complement if col_msb; then shift left by col_idx.
  - mul = col_mul_en ? ((sum of group_sum) * col_mul_const) << col_mul_shift : 0.
- Pipeline: stage 1 registers shifted tot + mul on column acceptance. Stage 2 does acc += stage1, sign-extended, wrapping mod 2^ACC_WIDTH. Column accepted at cycle t affects acc at t+2.
- Stage 1 is zero-filled on cycles with no handshake, so bubbles add 0.
- A column presented while col_ready=0 is held upstream and is never dropped.

Decomposition:
- Shared package mac_vert_pkg: the derived width functions (GSUM_W, slot-to-index mapping) and an FSM state enum typedef.
- Sub-module mac_vert_col_term: combinational slot mux, psum/term/tot computation, negate and shift. Instantiated once.

Test Plan:
- Reset asserted 3 cycles: out_valid=0, col_ready=0, act_ready=1, acc_out=0, err_overflow=0.
- Setup: act[i]=i (i=0..15), one column, all sel=0/val=1, skip_zero=0 both groups, col_idx=3, col_msb=1, last=1. Terms are 28-6=22 and 92-38=54; tot=76; response: acc_out = -608.
- Same act, all val=0, skip_zero=1, mul_en=1, const=1, shift=2, last -> acc_out=480, result=1.
- load_accum=1, accum_prev=1000, act all 1, column sel=0/val=1, skip_zero=1, idx=0, last -> acc_out=1008.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid, acc_out stable; act_ready=0, col_ready=0. Pulse out_ready -> IDLE the next cycle.
- Send 8 columns with col_last=0 -> DRAIN after the 8th; err_overflow=1; col_ready=0.
- Assert reset during RUN -> IDLE, acc_out=0, no out_valid.
